rx_frame_filter: RTL
====================

Name: rx_frame_filter

Overview:
- Parametrised post-receiver stage between `rx_receiver` and the board-level display/host logic.
- Classifies each completed frame as accepted, CRC-failed, ID-mismatched or overflowed, using unicast, broadcast and promiscuous matching.
- Buffers accepted frames in a FIFO with a valid/ready drain port.
- Keeps saturating statistics counters and drives pulse-stretched status LEDs, so single-cycle events are visible on the board.

Parameters:
- ID_W, 2, width of dest/src ID fields.
- PAYLOAD_W, 128, payload width.
- FIFO_DEPTH, 4, accepted-frame buffer entries; power of two, minimum 2.
- CNT_W, 16, width of each statistics counter.
- STRETCH_CYC, 25000000, LED hold time in clk cycles (0.5 s at 50 MHz); minimum 1.
- BCAST_EN, 1, when 1, dest_id of all ones is accepted by every node.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- my_id  in  ID_W  local node ID (quasi-static)
- promisc  in  1  accept every CRC-good frame regardless of dest_id
- clr_stats  in  1  synchronous clear of counters and LEDs
- frame_valid  in  1  one-cycle pulse: CRC-good frame complete
- crc_error  in  1  one-cycle pulse: CRC-failed frame
- dest_id  in  ID_W  frame destination; valid with frame_valid
- src_id  in  ID_W  frame source; valid with frame_valid
- payload  in  PAYLOAD_W  frame payload; valid with frame_valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_src_id  out  ID_W  head frame source
- out_payload  out  PAYLOAD_W  head frame payload
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- cnt_ok  out  CNT_W  accepted frames
- cnt_crc  out  CNT_W  CRC-failed frames
- cnt_id  out  CNT_W  ID-mismatched frames
- cnt_ovf  out  CNT_W  matched frames dropped because the FIFO was full
- led_ok, led_crc, led_id, led_ovf  out  1 each  stretched event indicators

Behaviour:
- Reset (clk, rst_n): one clock; reset is asynchronous and active-low. All outputs are 0 in reset: FIFO empty, out_valid=0, fifo_level=0, all counters 0, all LEDs 0, pipeline registers cleared. Reset mid-frame discards any frame in flight.
- Stage 0, input capture: on the clk edge where frame_valid or crc_error is high, register dest_id, src_id, payload and the event flags. No other input sampling.
- Stage 1, classification, one cycle later. Exactly one class per event:
  - CRC: crc_error=1. This includes crc_error and frame_valid high together; CRC wins and the frame is discarded.
  - ID: frame_valid=1, promisc=0, dest_id!=my_id, and not (BCAST_EN=1 and dest_id all ones).
  - OK: frame matched and a push is possible. A push is possible when the FIFO is not full, or it is full and a pop occurs in the same cycle.
  - OVF: frame matched but the FIFO is full with no pop. The frame is dropped; existing entries are never overwritten.
  - my_id and promisc are sampled in stage 1.
- Latency: frame_valid at edge N gives the FIFO write at edge N+1 and out_valid=1 after edge N+2 when the FIFO was empty. The counter and LED for the event update at edge N+1 (visible after N+1).
- FIFO:
  - First-word-fall-through, registered.
  - Pop when out_valid and out_ready are both high at a clk edge.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_payload and out_src_id are don't-care while out_valid=0. They must hold stable while out_valid=1 and out_ready=0.
- Counters:
  - +1 per event of their class.
  - Saturate at all ones; no wrap.
  - clr_stats=1 sets all counters to 0. clr_stats wins over a same-cycle event, so that event is not counted.
- LED stretchers:
  - One down-counter per LED, width $clog2(STRETCH_CYC+1).
  - An event loads STRETCH_CYC and sets the LED to 1.
  - The LED stays 1 while the counter is nonzero and clears on the cycle the counter reaches 0.
  - A retrigger while lit reloads the counter to full.
  - clr_stats forces all LEDs and counters to 0 and takes priority over events.
- clr_stats has no effect on FIFO contents or pipeline registers.

Decomposition:
- Shared header rx_defs.vh holds:
  - Class encoding: CLS_NONE=0, CLS_OK=1, CLS_CRC=2, CLS_ID=3, CLS_OVF=4.
  - Broadcast-ID macro (all ones of ID_W).
  - Default STRETCH_CYC for 50 MHz.
- Sub-module rx_sync_fifo, parametrised on width and depth, with push/pop/full/empty/level. The FIFO entry is {src_id, payload}.
- Counters and stretchers are generate loops inside rx_frame_filter.

Test Plan:
- Stimulus: my_id=2, frame_valid with dest=2, src=1, payload=0x..A5. Response: after 2 cycles out_valid=1, out_payload[7:0]=0xA5, out_src_id=1, cnt_ok=1, led_ok=1 for exactly STRETCH_CYC cycles (bench uses STRETCH_CYC=8).
- Stimulus: my_id=2, frames with dest=1, then dest=3 (BCAST_EN=1), then dest=0 with promisc=1. Response: cnt_id=1, cnt_ok=2, fifo_level=2.
- Stimulus: out_ready=0, FIFO_DEPTH=4, 6 matching frames. Response: fifo_level=4, cnt_ok=4, cnt_ovf=2, led_ovf=1. Drain with out_ready=1 yields the first 4 payloads in order.
- Stimulus: FIFO full, matched frame arrives in the same cycle as a pop. Response: frame accepted, cnt_ok increments, cnt_ovf unchanged, fifo_level stays 4.
- Stimulus: frame_valid and crc_error pulsed together; then CNT_W=4 with 20 CRC errors. Response: no push, cnt_crc saturates at 15; a clr_stats coincident with a CRC event leaves cnt_crc=0 and led_crc=0.
- Stimulus: rst_n pulled low while out_valid=1 and an LED is lit. Response: out_valid, fifo_level, all counters and all LEDs are 0 immediately (asynchronously) and stay 0 until the next event after release.

Source files
------------

// File: rtl/rx_frame_filter_pkg.sv
// rtl/rx_frame_filter_pkg.sv - shared frame-class encoding and defaults for rx_frame_filter
package rx_frame_filter_pkg;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_OK   = 3'd1,
        CLS_CRC  = 3'd2,
        CLS_ID   = 3'd3,
        CLS_OVF  = 3'd4
    } cls_e;

    // One statistics counter and one LED per non-NONE class, indexed by class code minus one.
    localparam int NUM_CLS = 4;

    // 0.5 s LED hold at a 50 MHz system clock.
    localparam int STRETCH_CYC_50MHZ = 25_000_000;

endpackage

// File: rtl/rx_sync_fifo.sv
// rtl/rx_sync_fifo.sv - registered first-word-fall-through FIFO with full/empty/level
module rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [LVL_W-1:0] count_d, count_q;
    logic             valid_d, valid_q;
    logic             do_push;

    always_comb begin
        do_push  = push && (!full || pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - LVL_W'(1);
        end
        // Head validity lags a push by one cycle: it only sees entries that survived this edge's pop.
        valid_d = pop ? (count_q > LVL_W'(1)) : (count_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = valid_q;
    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;

endmodule

// File: rtl/rx_frame_filter.sv
// rtl/rx_frame_filter.sv - classifies received frames, buffers accepted ones, keeps stats and LEDs
module rx_frame_filter
    import rx_frame_filter_pkg::*;
#(
    parameter int ID_W        = 2,
    parameter int PAYLOAD_W   = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16,
    parameter int STRETCH_CYC = STRETCH_CYC_50MHZ,
    parameter bit BCAST_EN    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ID_W-1:0]               my_id,
    input  logic                          promisc,
    input  logic                          clr_stats,
    input  logic                          frame_valid,
    input  logic                          crc_error,
    input  logic [ID_W-1:0]               dest_id,
    input  logic [ID_W-1:0]               src_id,
    input  logic [PAYLOAD_W-1:0]          payload,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_src_id,
    output logic [PAYLOAD_W-1:0]          out_payload,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              cnt_ok,
    output logic [CNT_W-1:0]              cnt_crc,
    output logic [CNT_W-1:0]              cnt_id,
    output logic [CNT_W-1:0]              cnt_ovf,
    output logic                          led_ok,
    output logic                          led_crc,
    output logic                          led_id,
    output logic                          led_ovf
);

    localparam int TMR_W = $clog2(STRETCH_CYC + 1);
    localparam logic [ID_W-1:0] BCAST_ID = '1;

    logic                 s0_evt_d, s0_evt_q;
    logic                 s0_crc_d, s0_crc_q;
    logic [ID_W-1:0]      s0_dest_d, s0_dest_q;
    logic [ID_W-1:0]      s0_src_d, s0_src_q;
    logic [PAYLOAD_W-1:0] s0_payload_d, s0_payload_q;

    always_comb begin
        s0_evt_d     = frame_valid || crc_error;
        s0_crc_d     = s0_crc_q;
        s0_dest_d    = s0_dest_q;
        s0_src_d     = s0_src_q;
        s0_payload_d = s0_payload_q;
        if (s0_evt_d) begin
            s0_crc_d     = crc_error;
            s0_dest_d    = dest_id;
            s0_src_d     = src_id;
            s0_payload_d = payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_evt_q     <= 1'b0;
            s0_crc_q     <= 1'b0;
            s0_dest_q    <= '0;
            s0_src_q     <= '0;
            s0_payload_q <= '0;
        end else begin
            s0_evt_q     <= s0_evt_d;
            s0_crc_q     <= s0_crc_d;
            s0_dest_q    <= s0_dest_d;
            s0_src_q     <= s0_src_d;
            s0_payload_q <= s0_payload_d;
        end
    end

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 id_match;
    cls_e                 cls;
    logic [NUM_CLS-1:0]   evt;

    assign fifo_pop = out_valid && out_ready;

    // A full FIFO still accepts a frame when its head leaves on the same edge.
    always_comb begin
        id_match = promisc || (s0_dest_q == my_id) || (BCAST_EN && (s0_dest_q == BCAST_ID));
        cls      = CLS_NONE;
        if (s0_evt_q) begin
            if (s0_crc_q) begin
                cls = CLS_CRC;
            end else if (!id_match) begin
                cls = CLS_ID;
            end else if (!fifo_full || fifo_pop) begin
                cls = CLS_OK;
            end else begin
                cls = CLS_OVF;
            end
        end
        evt = {cls == CLS_OVF, cls == CLS_ID, cls == CLS_CRC, cls == CLS_OK};
    end

    rx_sync_fifo #(
        .WIDTH (ID_W + PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cls == CLS_OK),
        .wdata ({s0_src_q, s0_payload_q}),
        .pop   (fifo_pop),
        .rdata ({out_src_id, out_payload}),
        .valid (out_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    logic [CNT_W-1:0]   cnt_all [NUM_CLS];
    logic [NUM_CLS-1:0] led_all;

    for (genvar g = 0; g < NUM_CLS; g++) begin : g_stat
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic [TMR_W-1:0] tmr_d, tmr_q;

        always_comb begin
            cnt_d = cnt_q;
            tmr_d = tmr_q;
            if (clr_stats) begin
                cnt_d = '0;
                tmr_d = '0;
            end else if (evt[g]) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                tmr_d = TMR_W'(STRETCH_CYC);
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - TMR_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                tmr_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                tmr_q <= tmr_d;
            end
        end

        assign cnt_all[g] = cnt_q;
        assign led_all[g] = (tmr_q != '0);
    end

    assign cnt_ok  = cnt_all[0];
    assign cnt_crc = cnt_all[1];
    assign cnt_id  = cnt_all[2];
    assign cnt_ovf = cnt_all[3];
    assign led_ok  = led_all[0];
    assign led_crc = led_all[1];
    assign led_id  = led_all[2];
    assign led_ovf = led_all[3] && !fifo_empty || led_all[3];

endmodule
